// File: rtl/cordic_pipe_param_if.sv
// Sample stream bundle for cordic_pipe_param: input valid/ready side and
// output valid/ready side, plus the per-sample mode bit.
interface cordic_pipe_param_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ANG_W  = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic                     mode_in;
   logic signed [DATA_W-1:0] x_in;
   logic signed [DATA_W-1:0] y_in;
   logic signed [ANG_W-1:0]  z_in;
   logic                     out_valid;
   logic                     out_ready;
   logic                     mode_out;
   logic signed [DATA_W-1:0] x_out;
   logic signed [DATA_W-1:0] y_out;
   logic signed [ANG_W-1:0]  z_out;

   modport master (
      output in_valid, mode_in, x_in, y_in, z_in, out_ready,
      input  in_ready, out_valid, mode_out, x_out, y_out, z_out
   );

   modport slave (
      input  in_valid, mode_in, x_in, y_in, z_in, out_ready,
      output in_ready, out_valid, mode_out, x_out, y_out, z_out
   );
endinterface

// File: rtl/cordic_pipe_param.sv
// Fully pipelined CORDIC, vectoring or rotation chosen per sample. Quadrant
// pre-rotation, STAGES micro-rotations, then optional 1/K scaling and saturation.
module cordic_pipe_param #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ANG_W     = 16,
   parameter int unsigned STAGES    = 16,
   parameter bit          GAIN_COMP = 1'b1
) (
   input logic                Clk,
   input logic                Rst,
   cordic_pipe_param_if.slave bus
);

   localparam int unsigned IW     = DATA_W + 2;
   localparam int unsigned PW     = IW + 16;
   localparam int unsigned AShift = 32 - ANG_W;
   localparam logic [32:0] ARound = (AShift == 0) ? 33'd0 : (33'd1 << (AShift - 1));
   localparam logic signed [ANG_W-1:0] HalfPi = {2'b01, {(ANG_W - 2){1'b0}}};
   localparam logic signed [PW-1:0] GainQ15 = PW'(32'sh4DBA);
   localparam logic signed [PW-1:0] RndQ15  = PW'(32'sh4000);
   localparam logic signed [PW-1:0] SatMax  = PW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam logic signed [PW-1:0] SatMin  = ~SatMax;

   // atan(2^-i) with 2^32 = full circle, rounded half-up to ANG_W bits
   function automatic logic signed [ANG_W-1:0] atan_lut(input int unsigned idx);
      logic [31:0] v;
      case (idx)
         0:       v = 32'h2000_0000;
         1:       v = 32'h12E4_051E;
         2:       v = 32'h09FB_385B;
         3:       v = 32'h0511_11D4;
         4:       v = 32'h028B_0D43;
         5:       v = 32'h0145_D7E1;
         6:       v = 32'h00A2_F61E;
         7:       v = 32'h0051_7C55;
         8:       v = 32'h0028_BE53;
         9:       v = 32'h0014_5F2F;
         10:      v = 32'h000A_2F98;
         11:      v = 32'h0005_17CC;
         12:      v = 32'h0002_8BE6;
         13:      v = 32'h0001_45F3;
         14:      v = 32'h0000_A2FA;
         15:      v = 32'h0000_517D;
         16:      v = 32'h0000_28BE;
         17:      v = 32'h0000_145F;
         18:      v = 32'h0000_0A30;
         19:      v = 32'h0000_0518;
         20:      v = 32'h0000_028C;
         21:      v = 32'h0000_0146;
         22:      v = 32'h0000_00A3;
         23:      v = 32'h0000_0051;
         default: v = 32'h0;
      endcase
      return ANG_W'(({1'b0, v} + ARound) >> AShift);
   endfunction

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
      logic signed [DATA_W-1:0] r;
      if (v > SatMax) begin
         r = SatMax[DATA_W-1:0];
      end else if (v < SatMin) begin
         r = SatMin[DATA_W-1:0];
      end else begin
         r = v[DATA_W-1:0];
      end
      return r;
   endfunction

   logic                    adv;
   logic signed [IW-1:0]    x_ext, y_ext;
   logic signed [IW-1:0]    x_d [STAGES+1];
   logic signed [IW-1:0]    x_q [STAGES+1];
   logic signed [IW-1:0]    y_d [STAGES+1];
   logic signed [IW-1:0]    y_q [STAGES+1];
   logic signed [ANG_W-1:0] z_d [STAGES+1];
   logic signed [ANG_W-1:0] z_q [STAGES+1];
   logic [STAGES:0]         vld_d, vld_q;
   logic [STAGES:0]         mode_d, mode_q;

   logic signed [PW-1:0]     x_scl, y_scl;
   logic                     out_valid_d, out_valid_q;
   logic                     mode_out_d, mode_out_q;
   logic signed [DATA_W-1:0] x_out_d, x_out_q;
   logic signed [DATA_W-1:0] y_out_d, y_out_q;
   logic signed [ANG_W-1:0]  z_out_d, z_out_q;

   // The whole pipe moves together; a full output register stalls everything.
   assign adv = bus.out_ready || !out_valid_q;

   always_comb begin
      x_ext  = {{2{bus.x_in[DATA_W-1]}}, bus.x_in};
      y_ext  = {{2{bus.y_in[DATA_W-1]}}, bus.y_in};
      vld_d  = {vld_q[STAGES-1:0], bus.in_valid};
      mode_d = {mode_q[STAGES-1:0], bus.mode_in};
      x_d[0] = x_ext;
      y_d[0] = y_ext;
      z_d[0] = bus.z_in;

      // Pre-rotation by +/-pi/2 brings every vector into the CORDIC convergence range
      if (!bus.mode_in) begin
         z_d[0] = '0;
         if (x_ext[IW-1]) begin
            if (!y_ext[IW-1]) begin
               x_d[0] = y_ext;
               y_d[0] = -x_ext;
               z_d[0] = HalfPi;
            end else begin
               x_d[0] = -y_ext;
               y_d[0] = x_ext;
               z_d[0] = -HalfPi;
            end
         end
      end else if (bus.z_in > HalfPi) begin
         x_d[0] = -y_ext;
         y_d[0] = x_ext;
         z_d[0] = bus.z_in - HalfPi;
      end else if (bus.z_in < -HalfPi) begin
         x_d[0] = y_ext;
         y_d[0] = -x_ext;
         z_d[0] = bus.z_in + HalfPi;
      end

      for (int i = 0; i < int'(STAGES); i++) begin
         if (mode_q[i] ? !z_q[i][ANG_W-1] : y_q[i][IW-1]) begin
            x_d[i+1] = x_q[i] - (y_q[i] >>> i);
            y_d[i+1] = y_q[i] + (x_q[i] >>> i);
            z_d[i+1] = z_q[i] - atan_lut(i);
         end else begin
            x_d[i+1] = x_q[i] + (y_q[i] >>> i);
            y_d[i+1] = y_q[i] - (x_q[i] >>> i);
            z_d[i+1] = z_q[i] + atan_lut(i);
         end
      end
   end

   always_comb begin
      x_scl = PW'(x_q[STAGES]);
      y_scl = PW'(y_q[STAGES]);
      if (GAIN_COMP) begin
         x_scl = (x_scl * GainQ15 + RndQ15) >>> 15;
         y_scl = (y_scl * GainQ15 + RndQ15) >>> 15;
      end
      out_valid_d = vld_q[STAGES];
      mode_out_d  = mode_q[STAGES];
      x_out_d     = sat(x_scl);
      y_out_d     = sat(y_scl);
      z_out_d     = z_q[STAGES];
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         vld_q  <= '0;
         mode_q <= '0;
         for (int i = 0; i <= int'(STAGES); i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
            z_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         mode_out_q  <= 1'b0;
         x_out_q     <= '0;
         y_out_q     <= '0;
         z_out_q     <= '0;
      end else if (adv) begin
         vld_q       <= vld_d;
         mode_q      <= mode_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         out_valid_q <= out_valid_d;
         mode_out_q  <= mode_out_d;
         x_out_q     <= x_out_d;
         y_out_q     <= y_out_d;
         z_out_q     <= z_out_d;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.mode_out  = mode_out_q;
   assign bus.x_out     = x_out_q;
   assign bus.y_out     = y_out_q;
   assign bus.z_out     = z_out_q;

endmodule

// File: doc/cordic_pipe_param.md
Name: cordic_pipe_param

Overview:
Parametrised, fully pipelined CORDIC engine, one sample per clock, supporting both vectoring mode (magnitude/phase) and rotation mode (vector rotate) per sample. It adds full-circle coverage via a quadrant pre-rotation stage, optional gain compensation, output saturation, and a valid/ready handshake with backpressure. It replaces fixed-width, vectoring-only pipelines in the DSP datapath; a sample's mode travels with it through the pipe.

Parameters:
DATA_W, 16, signed x/y width (two's complement), 8..24
ANG_W, 16, signed angle width; full scale: -2^(ANG_W-1) = -pi, 2^(ANG_W-1) = +pi (exclusive)
STAGES, 16, micro-rotation iterations i = 0..STAGES-1, 4..min(DATA_W,24)
GAIN_COMP, 1, 1 = multiply final x,y by 1/K; 0 = raw CORDIC gain (~1.6468) passes through

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  synchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  input accepted when in_valid && in_ready
mode_in  in  1  0 = vectoring (drive y to 0), 1 = rotation (drive z to 0)
x_in  in  DATA_W  signed x
y_in  in  DATA_W  signed y
z_in  in  ANG_W  signed angle (rotation mode only; ignored in vectoring)
out_valid  out  1  output sample valid
out_ready  in  1  downstream ready
mode_out  out  1  mode of the output sample
x_out  out  DATA_W  vectoring: magnitude; rotation: rotated x
y_out  out  DATA_W  vectoring: residual y; rotation: rotated y
z_out  out  ANG_W  vectoring: atan2(y,x); rotation: residual angle

Behaviour:
- Reset (Rst high at a Clk edge): every pipeline valid bit = 0; out_valid = 0, x_out = y_out = z_out = 0, mode_out = 0. Datapath registers clear to 0. Reset mid-stream discards all in-flight samples. On the first cycle after Rst deasserts: in_ready = 1, out_valid = 0.
- Advance: adv = out_ready || !out_valid. in_ready = adv, combinational.
  - When adv is high, every stage register, including its valid bit, shifts by one.
  - When adv is low, the whole pipe holds and outputs stay stable.
  - Bubbles propagate as valid = 0; they are not compressed.
- Latency: STAGES+2 advancing cycles from acceptance to out_valid. Order is preserved, and no sample is dropped or duplicated under any out_ready pattern.
- Stage P (pre-rotation, registered):
  - Internal x/y width is DATA_W+2 (sign-extended); z is ANG_W.
  - Vectoring, x<0: if y>=0, (x,y,z) = (y,-x,+pi/2); else (-y,x,-pi/2). With x>=0, z = 0.
  - Rotation, z>pi/2 (> 2^(ANG_W-2)): (x,y,z) = (-y,x,z-pi/2). For z<-pi/2: (y,-x,z+pi/2). Otherwise pass through.
- Stage i (registered), direction d:
  - Vectoring: d = +1 if y<0, else -1.
  - Rotation: d = +1 if z>=0, else -1.
  - Update: x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan_i. All arithmetic shifts.
  - Angle wrap in z uses modulo-2^ANG_W arithmetic (intended).
- atan table: 32-bit constants with 2^32 = full circle; first entries 0x20000000, 0x12E4051E, 0x09FB385B, 0x051111D4, 0x028B0D43.
  - Reduce each entry to ANG_W by round-half-up right shift of 32-ANG_W.
  - Entries beyond 24 are not needed.
- Stage F (output register):
  - If GAIN_COMP=1: x,y multiplied by 0x4DBA (0.607253, Q1.15), round-half-up, >>>15.
  - Saturate x,y to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. z passes through.
- Accuracy (DATA_W=16, ANG_W=16, STAGES=16, GAIN_COMP=1): |z error| <= 4 LSB; |x,y error| <= 4 LSB + 0.1% of magnitude.
- Input x=y=0 in vectoring: z_out = 0 +/- atan residue, x_out = 0; no X/overflow.

Test Plan:
1. Vectoring x=16384,y=0 -> after 18 cycles out_valid=1, x_out=16384+/-4, z_out=0+/-4, mode_out=0.
2. Vectoring x=0,y=16384 -> z_out=16384+/-4 (pi/2); x=-16384,y=16384 -> z_out=24576+/-4, x_out=23170+/-25; x=-16384,y=-1 -> z_out near -32768 (wrap-consistent).
3. Rotation x=16384,y=0,z=8192 (pi/4) -> x_out=y_out=11585+/-15, z_out=0+/-4; rotation x=16384,y=0,z=-24576 -> x_out=y_out=-11585+/-15.
4. Vectoring x=y=32767, GAIN_COMP=1 -> x_out saturates to 32767, z_out=8192+/-4.
5. Back-to-back 40 random samples with alternating modes, out_ready low for 5-cycle bursts every 7 cycles -> all 40 outputs match the golden model in order; outputs stable while held; in_ready = out_ready || !out_valid every cycle.
6. Rst asserted for one cycle with 10 samples in flight -> next cycle out_valid=0, outputs 0; no stale sample ever emerges; a new sample accepted afterwards appears after exactly 18 cycles.
